// File: rtl/fpga_msg_arb_if.sv
// fpga_msg_arb_if: producer-side requests, FIFO write port and drop statistics of the message arbiter
interface fpga_msg_arb_if #(parameter int N_SRC = 4, parameter int DW = 128, parameter int CNT_W = 16);
  logic [N_SRC-1:0] src_req, src_last, src_en, src_ack;
  logic [N_SRC*DW-1:0] src_data;
  logic host_open, fifo_afull, fifo_wr_en, busy, drop_flag;
  logic [DW-1:0] fifo_din;
  logic [CNT_W-1:0] drop_cnt;
  modport master (
    output src_req, src_last, src_data, src_en, host_open, fifo_afull,
    input src_ack, fifo_din, fifo_wr_en, busy, drop_cnt, drop_flag
  );
  modport slave (
    input src_req, src_last, src_data, src_en, host_open, fifo_afull,
    output src_ack, fifo_din, fifo_wr_en, busy, drop_cnt, drop_flag
  );
endinterface

// File: rtl/fpga_msg_arb.sv
// fpga_msg_arb: packet-level round-robin arbiter into the host message FIFO, dropping packets while the host is closed.
// Optional FPGA_MSG_ARB_TAG_EN stamps the source index into fifo_din[DW-1:DW-4].
module fpga_msg_arb #(
  parameter int N_SRC = 4,
  parameter int DW = 128,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  fpga_msg_arb_if.slave bus
);
  localparam int IW = $clog2(N_SRC);
  typedef enum logic [1:0] {IDLE, LOCK, DRAIN} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, lsrc_q, lsrc_d, win, idx, sel;
  logic found, take, fwd, drop, last;
  logic [DW-1:0] dat [N_SRC];
  logic [DW-1:0] raw, data, fifo_din_q;
  logic fifo_wr_en_q, drop_flag_q;
  logic [CNT_W-1:0] drop_cnt_q;
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
    return (x == IW'(N_SRC - 1)) ? '0 : x + IW'(1);
  endfunction
  for (genvar g = 0; g < N_SRC; g++) begin : g_dat
    assign dat[g] = bus.src_data[g*DW +: DW];
  end
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    // descending scan so the source closest to rr is the final winner
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_q) + k) % N_SRC);
      if (bus.src_req[idx] && bus.src_en[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    sel = (state_q == IDLE) ? win : lsrc_q;
    last = bus.src_last[sel];
    take = (state_q == IDLE) ? found && (!bus.host_open || !bus.fifo_afull)
         : (state_q == LOCK) ? bus.src_req[lsrc_q] && (!bus.host_open || !bus.fifo_afull)
         : bus.src_req[lsrc_q];
    fwd = take && bus.host_open && (state_q != DRAIN);
    drop = take && !fwd;
    state_d = state_q;
    rr_d = rr_q;
    lsrc_d = lsrc_q;
    if (take && last) begin
      state_d = IDLE;
      rr_d = inc(sel);
    end else if (take && state_q == IDLE) begin
      state_d = bus.host_open ? LOCK : DRAIN;
      lsrc_d = win;
    end else if (state_q == LOCK && !bus.host_open) begin
      state_d = DRAIN;
    end
  end
  assign raw = dat[sel];
`ifdef FPGA_MSG_ARB_TAG_EN
  assign data = {4'(sel), raw[DW-5:0]};
`else
  assign data = raw;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q <= '0;
      lsrc_q <= '0;
      fifo_wr_en_q <= 1'b0;
      fifo_din_q <= '0;
      drop_cnt_q <= '0;
      drop_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      lsrc_q <= lsrc_d;
      fifo_wr_en_q <= fwd;
      if (fwd) fifo_din_q <= data;
      if (drop && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      if (drop) drop_flag_q <= 1'b1;
    end
  end
  assign bus.src_ack = take ? (N_SRC'(1) << sel) : '0;
  assign bus.fifo_din = fifo_din_q;
  assign bus.fifo_wr_en = fifo_wr_en_q;
  assign bus.busy = state_q != IDLE;
  assign bus.drop_cnt = drop_cnt_q;
  assign bus.drop_flag = drop_flag_q;
endmodule

// File: tb/tb_fpga_msg_arb.sv
// tb_fpga_msg_arb: directed scoreboard bench; stimulus queues expected FIFO writes, a monitor pops and compares them.
module tb_fpga_msg_arb;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  typedef struct {logic [127:0] d; int c;} exp_t;
  exp_t q[$];
  fpga_msg_arb_if #(.N_SRC(4), .DW(128), .CNT_W(16)) b();
  fpga_msg_arb_if #(.N_SRC(4), .DW(128), .CNT_W(4)) b4();
  fpga_msg_arb #(.N_SRC(4), .DW(128), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(b));
  fpga_msg_arb #(.N_SRC(4), .DW(128), .CNT_W(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  assign b4.src_req = b.src_req;
  assign b4.src_last = b.src_last;
  assign b4.src_data = b.src_data;
  assign b4.src_en = b.src_en;
  assign b4.host_open = b.host_open;
  assign b4.fifo_afull = b.fifo_afull;
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  function automatic void chk(input string n, input logic [127:0] a, input logic [127:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endfunction
  function automatic logic [127:0] dv(input int s, input int bt);
    return {16'hC0DE, 8'(s), 8'(bt), 96'h0123_4567_89AB_CDEF_0011_2233};
  endfunction
  task automatic setd(input int s, input logic [127:0] v);
    b.src_data[s*128 +: 128] = v;
  endtask
  task automatic step(input logic [3:0] eack, input bit fwd, input logic [127:0] d);
    exp_t e;
    @(negedge clk);
    chk("src_ack", 128'(b.src_ack), 128'(eack));
    if (fwd) begin
      e.d = d;
      e.c = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (b.fifo_wr_en) begin
      if (q.size() == 0) chk("unexpected_wr", 128'(b.fifo_wr_en), 128'(0));
      else begin
        e = q.pop_front();
        chk("fifo_din", b.fifo_din, e.d);
        chk("wr_cycle", 128'(cyc), 128'(e.c));
      end
    end else if (q.size() != 0 && q[0].c < cyc) begin
      e = q.pop_front();
      chk("missing_wr", 128'(b.fifo_wr_en), 128'(1));
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end
  initial begin
    b.src_req = '0;
    b.src_last = '0;
    b.src_en = '1;
    b.src_data = '0;
    b.host_open = 1'b1;
    b.fifo_afull = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 128'(b.fifo_wr_en), 128'(0));
    chk("rst_din", b.fifo_din, 128'(0));
    chk("rst_busy", 128'(b.busy), 128'(0));
    chk("rst_cnt", 128'(b.drop_cnt), 128'(0));
    chk("rst_flag", 128'(b.drop_flag), 128'(0));
    reset = 1'b1;
    // round robin over four single-beat packets, then source 0 first again
    b.src_last = '1;
    for (int s = 0; s < 4; s++) setd(s, dv(s, 0));
    b.src_req = '1;
    for (int s = 0; s < 4; s++) begin
      step(4'(1 << s), 1, dv(s, 0));
      b.src_req[s] = 1'b0;
    end
    setd(0, dv(0, 1));
    setd(2, dv(2, 1));
    b.src_req = 4'b0101;
    step(4'b0001, 1, dv(0, 1));
    b.src_req[0] = 1'b0;
    step(4'b0100, 1, dv(2, 1));
    b.src_req[2] = 1'b0;
    // locking: src1 waits out src0's 3-beat packet
    b.src_last = 4'b0010;
    setd(0, dv(0, 10));
    setd(1, dv(1, 10));
    b.src_req = 4'b0011;
    step(4'b0001, 1, dv(0, 10));
    setd(0, dv(0, 11));
    step(4'b0001, 1, dv(0, 11));
    setd(0, dv(0, 12));
    b.src_last[0] = 1'b1;
    chk("busy_lock", 128'(b.busy), 128'(1));
    step(4'b0001, 1, dv(0, 12));
    b.src_req[0] = 1'b0;
    step(4'b0010, 1, dv(1, 10));
    b.src_req[1] = 1'b0;
    // backpressure mid-packet while src3 requests
    b.src_last = 4'b1000;
    setd(2, dv(2, 20));
    setd(3, dv(3, 20));
    b.src_req = 4'b0100;
    step(4'b0100, 1, dv(2, 20));
    setd(2, dv(2, 21));
    step(4'b0100, 1, dv(2, 21));
    setd(2, dv(2, 22));
    b.fifo_afull = 1'b1;
    b.src_req[3] = 1'b1;
    repeat (5) step(4'b0000, 0, '0);
    b.fifo_afull = 1'b0;
    step(4'b0100, 1, dv(2, 22));
    setd(2, dv(2, 23));
    b.src_last[2] = 1'b1;
    step(4'b0100, 1, dv(2, 23));
    b.src_req[2] = 1'b0;
    step(4'b1000, 1, dv(3, 20));
    b.src_req[3] = 1'b0;
    // host closes after beat 2 of a 6-beat packet
    b.src_last = '0;
    setd(3, dv(3, 30));
    b.src_req = 4'b1000;
    step(4'b1000, 1, dv(3, 30));
    setd(3, dv(3, 31));
    step(4'b1000, 1, dv(3, 31));
    setd(3, dv(3, 32));
    b.host_open = 1'b0;
    step(4'b1000, 0, '0);
    b.host_open = 1'b1;
    setd(3, dv(3, 33));
    step(4'b1000, 0, '0);
    setd(3, dv(3, 34));
    b.fifo_afull = 1'b1;
    step(4'b1000, 0, '0);
    b.fifo_afull = 1'b0;
    setd(3, dv(3, 35));
    b.src_last[3] = 1'b1;
    step(4'b1000, 0, '0);
    b.src_req = '0;
    b.src_last = '0;
    chk("drop_cnt4", 128'(b.drop_cnt), 128'(4));
    chk("drop_flag", 128'(b.drop_flag), 128'(1));
    setd(0, dv(0, 40));
    b.src_req = 4'b0001;
    step(4'b0001, 1, dv(0, 40));
    setd(0, dv(0, 41));
    b.src_last[0] = 1'b1;
    step(4'b0001, 1, dv(0, 41));
    b.src_req = '0;
    // reset for one cycle in the middle of a locked packet
    b.src_last = '0;
    setd(1, dv(1, 50));
    b.src_req = 4'b0010;
    step(4'b0010, 1, dv(1, 50));
    setd(1, dv(1, 51));
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    b.src_req = '0;
    #1;
    chk("mid_rst_ack", 128'(b.src_ack), 128'(0));
    chk("mid_rst_wr_en", 128'(b.fifo_wr_en), 128'(0));
    chk("mid_rst_din", b.fifo_din, 128'(0));
    chk("mid_rst_busy", 128'(b.busy), 128'(0));
    chk("mid_rst_cnt", 128'(b.drop_cnt), 128'(0));
    chk("mid_rst_flag", 128'(b.drop_flag), 128'(0));
    b.src_last = 4'b0011;
    setd(0, dv(0, 60));
    setd(1, dv(1, 60));
    b.src_req = 4'b0011;
    step(4'b0001, 1, dv(0, 60));
    b.src_req[0] = 1'b0;
    step(4'b0010, 1, dv(1, 60));
    b.src_req = '0;
    // saturation: closed host drops 20 single-beat packets even with afull high
    b.host_open = 1'b0;
    b.fifo_afull = 1'b1;
    b.src_last = 4'b0001;
    b.src_req = 4'b0001;
    repeat (15) step(4'b0001, 0, '0);
    chk("sat4_at15", 128'(b4.drop_cnt), 128'(15));
    chk("cnt16_at15", 128'(b.drop_cnt), 128'(15));
    repeat (5) step(4'b0001, 0, '0);
    chk("sat4_at20", 128'(b4.drop_cnt), 128'(15));
    chk("cnt16_at20", 128'(b.drop_cnt), 128'(20));
    chk("sat4_flag", 128'(b4.drop_flag), 128'(1));
    b.src_req = '0;
    b.host_open = 1'b1;
    b.fifo_afull = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 128'(q.size()), 128'(0));
    chk("end_busy", 128'(b.busy), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/fpga_msg_arb.md
# fpga_msg_arb

Packet-level round-robin arbiter sharing the single FPGA-to-host message FIFO (128-bit write port feeding the xillybus read stream) among up to N_SRC message producers: camera-link frame data, status/housekeeping and command replies. Sits in the camera-clock domain between the producers and the FIFO write port. Never interleaves packets. While the host has the read stream closed, it keeps producers flowing by discarding their packets and counting the dropped beats.

## Interface
- N_SRC, 4: number of requesters, 2..8.
- DW, 128: message word width, matching the FIFO write port.
- CNT_W, 16: width of the drop counter.

- clk  in  1  camera-link pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- src_req  in  N_SRC  source i has a valid beat on src_data[i].
- src_last  in  N_SRC  beat on source i is the last of its packet.
- src_data  in  N_SRC*DW  flattened; source i occupies bits [i*DW +: DW].
- src_en  in  N_SRC  source i may win a new grant.
- src_ack  out  N_SRC  one-hot beat accepted from source i this cycle; combinational.
- host_open  in  1  host has the read stream open.
- fifo_afull  in  1  FIFO has at most 1 free entry.
- fifo_din  out  DW  registered write data.
- fifo_wr_en  out  1  registered write strobe.
- busy  out  1  state != IDLE.
- drop_cnt  out  CNT_W  saturating count of discarded beats.
- drop_flag  out  1  sticky; set on the first discarded beat.

## Operation
- States: IDLE, LOCK (forwarding a packet from lsrc), DRAIN (discarding the rest of a packet from lsrc).
- Pointer rr: index of the highest-priority source. Search order is rr, rr+1, … mod N_SRC.
- IDLE:
  - The winner is the first i in search order with src_req[i] & src_en[i].
  - Accept condition: winner exists AND (host_open=0 OR fifo_afull=0).
  - On accept, src_ack[winner]=1 in the same cycle.
  - host_open=1: the beat is forwarded.
    - src_last=1: stay in IDLE, rr←winner+1.
    - src_last=0: go to LOCK, lsrc←winner.
  - host_open=0: the beat is dropped.
    - src_last=1: rr←winner+1.
    - src_last=0: go to DRAIN, lsrc←winner.
- LOCK:
  - Only lsrc is served; src_en and all other requests are ignored.
  - Beat accepted when src_req[lsrc]=1 AND fifo_afull=0 AND host_open=1.
  - Accepted beat with last=1: go to IDLE, rr←lsrc+1.
  - host_open=0 takes priority over everything else in LOCK: go to DRAIN. The beat presented in that cycle is acked and dropped. If it carries last=1, go to IDLE instead of DRAIN.
- DRAIN:
  - Ack src_req[lsrc] every cycle, regardless of fifo_afull and host_open.
  - Every beat is dropped.
  - Leave on last=1: go to IDLE, rr←lsrc+1.
  - host_open returning to 1 does not end DRAIN: partial packets never reach the FIFO.
- Drop: drop_cnt += 1 per dropped beat, saturating at 2^CNT_W−1; drop_flag←1. Both are cleared only by reset.
- fifo_afull=1 with host_open=1: no ack, and state, rr and lsrc are held.
- fifo_din/fifo_wr_en are the registered copy of the forwarded beat. With no forward, fifo_wr_en=0 and fifo_din holds its previous value.

## Timing
- Reset values:
  - state=IDLE, rr=0, lsrc=0.
  - src_ack=0, fifo_wr_en=0, fifo_din=0.
  - busy=0, drop_cnt=0, drop_flag=0.
- src_ack: 0-cycle latency from src_req.
- fifo_wr_en: asserted in cycle t+1 for a beat acked in cycle t.
- Throughput: one beat per cycle.
- No bubble between back-to-back packets: IDLE grants and accepts in the same cycle.
- fifo_afull margin: it is sampled in cycle t. One registered write may already be in flight, so afull must assert with ≤1 free entry.
- reset=0 mid-packet: the packet is abandoned with no flush. A write issued in the preceding cycle still completes. Outputs reach reset values at the next edge.
- Producers must hold src_data/src_last stable until acked.

## Configuration
- FPGA_MSG_ARB_TAG_EN defined: fifo_din[DW-1:DW-4] is replaced by the 4-bit source index, so the host can demultiplex. Producers must leave those bits free.
- FPGA_MSG_ARB_TAG_EN undefined: src_data is passed through unmodified.

## Test plan
- Round-robin: sources 0..3 each hold a 1-beat packet, host_open=1, afull=0 → fifo_wr_en on 4 consecutive cycles with data order 0,1,2,3. Then source 0 is served again first.
- Locking: src0 sends a 3-beat packet while src1 requests continuously → src1 acked only in the cycle after src0's last beat. No interleave on fifo_din.
- Backpressure: afull=1 for 5 cycles mid-packet → src_ack=0 and fifo_wr_en=0 (after its 1-cycle pipeline) for those cycles. Packet resumes intact; no beat lost or duplicated.
- Host close mid-packet: host_open falls after beat 2 of a 6-beat packet, rises 1 cycle later → beats 3..6 acked and dropped, drop_cnt=4, drop_flag=1. The next packet is forwarded whole.
- Saturation: CNT_W=4, host_open=0, 20 single-beat packets → drop_cnt=15.
- Reset mid-LOCK: reset=0 for 1 cycle → all outputs 0 next edge, rr=0, state IDLE.
